// File: rtl/logic_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_pipe_if
// Description : Valid/ready bundle for logic_pipe. Upstream offers I/K/MODE,
//               downstream receives O (and O_PAR with LOGIC_PIPE_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_pipe_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] K;
    logic [1:0]       MODE;
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             O_READY;
`ifdef LOGIC_PIPE_PARITY_EN
    logic             O_PAR;
`endif

    modport master (
        output I,
        output K,
        output MODE,
        output I_VALID,
        input  I_READY,
        input  O,
        input  O_VALID,
`ifdef LOGIC_PIPE_PARITY_EN
        input  O_PAR,
`endif
        output O_READY
    );

    modport slave (
        input  I,
        input  K,
        input  MODE,
        input  I_VALID,
        output I_READY,
        output O,
        output O_VALID,
`ifdef LOGIC_PIPE_PARITY_EN
        output O_PAR,
`endif
        input  O_READY
    );
endinterface : logic_pipe_if
`default_nettype wire

// File: rtl/logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_pipe
// Description : Per-bit NOT/AND/OR/XOR unit behind a 2-entry skid buffer.
//               Optional macro LOGIC_PIPE_PARITY_EN adds a stored O_PAR bit.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_pipe #(
    parameter int WIDTH = 3
) (
    input  wire          CLK,
    input  wire          RESETN,
    logic_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;

    logic             w_accept;
    logic             w_release;
    logic [WIDTH-1:0] w_result;

    function automatic logic [WIDTH-1:0] f_logic_op(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (mode)
            2'b00:   res = ~a;
            2'b01:   res = a & b;
            2'b10:   res = a | b;
            default: res = a ^ b;
        endcase
        return res;
    endfunction

    // Handshakes use only registered ready/valid, so O_READY never reaches I_READY.
    assign w_accept  = bus.I_VALID & r_in_ready;
    assign w_release = r_out_valid & bus.O_READY;
    assign w_result  = f_logic_op(bus.MODE, bus.I, bus.K);

`ifdef LOGIC_PIPE_PARITY_EN
    logic r_head_par;
    logic r_skid_par;
    logic w_result_par;

    assign w_result_par = ^w_result;
    assign bus.O_PAR    = r_head_par;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= S_EMPTY;
            r_head      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
`ifdef LOGIC_PIPE_PARITY_EN
            r_head_par  <= 1'b0;
            r_skid_par  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_EMPTY: begin
                    // in_ready is low only on the first edge after reset
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_head      <= w_result;
`ifdef LOGIC_PIPE_PARITY_EN
                        r_head_par  <= w_result_par;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end

                S_ONE: begin
                    case ({w_accept, w_release})
                        2'b11: begin
                            r_head     <= w_result;
`ifdef LOGIC_PIPE_PARITY_EN
                            r_head_par <= w_result_par;
`endif
                        end
                        2'b10: begin
                            r_skid     <= w_result;
`ifdef LOGIC_PIPE_PARITY_EN
                            r_skid_par <= w_result_par;
`endif
                            r_in_ready <= 1'b0;
                            r_state    <= S_FULL;
                        end
                        2'b01: begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_EMPTY;
                        end
                        default: ;
                    endcase
                end

                S_FULL: begin
                    if (w_release) begin
                        r_head     <= r_skid;
`ifdef LOGIC_PIPE_PARITY_EN
                        r_head_par <= r_skid_par;
`endif
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_EMPTY;
                end
            endcase
        end
    end

    assign bus.I_READY = r_in_ready;
    assign bus.O_VALID = r_out_valid;
    assign bus.O       = r_head;

endmodule : logic_pipe
`default_nettype wire

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 3, data width in bits (legal 1..32).
REQ-002 SHALL have port: CLK  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: RESETN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: I  input  WIDTH  operand A.
REQ-005 SHALL have port: K  input  WIDTH  operand B (mask); ignored in MODE 00.
REQ-006 SHALL have port: MODE  input  2  operation select, sampled with I/K on accept.
REQ-007 SHALL have port: I_VALID  input  1  upstream offers I/K/MODE.
REQ-008 SHALL have port: I_READY  output  1  block accepts this cycle.
REQ-009 SHALL have port: O  output  WIDTH  result of head entry.
REQ-010 SHALL have port: O_VALID  output  1  O holds a valid result.
REQ-011 SHALL have port: O_READY  input  1  downstream consumes this cycle.

Function
REQ-012 SHALL compute per bit: MODE 00 ~I; 01 I&K; 10 I|K; 11 I^K; result exactly WIDTH bits, no carry or extension.
REQ-013 SHALL accept an input on a rising CLK edge iff I_VALID=1 and I_READY=1; SHALL release a result iff O_VALID=1 and O_READY=1.
REQ-014 SHALL hold results in a 2-entry buffer: output register (head) plus skid register; states EMPTY, ONE, FULL.
REQ-015 SHALL drive I_READY=1 in EMPTY and ONE and I_READY=0 in FULL, from registered state only (no combinational path from O_READY).
REQ-016 SHALL drive O_VALID=1 in ONE and FULL and O_VALID=0 in EMPTY; O from head register only.
REQ-017 Transitions: EMPTY+accept -> ONE (1-cycle latency); ONE+accept+release -> ONE (head reloads with new result); ONE+accept only -> FULL (result to skid); ONE+release only -> EMPTY; FULL+release -> ONE (skid moves to head); otherwise hold.
REQ-018 SHALL sustain one transfer per cycle when O_READY is held 1, and preserve strict FIFO order.
REQ-019 SHALL keep O and O_VALID stable while O_VALID=1 and O_READY=0.
REQ-020 In FULL SHALL ignore I_VALID/I/K/MODE; no entry overwritten or dropped.
REQ-021 O contents SHALL be don't-care while O_VALID=0.

Reset
REQ-022 RESETN=0 SHALL asynchronously force state EMPTY, O_VALID=0, O=0, skid=0, I_READY=0 while asserted.
REQ-023 On RESETN deassertion SHALL present I_READY=1 from the first following CLK edge; entries in flight at reset are discarded.

Configuration
REQ-024 Macro LOGIC_PIPE_PARITY_EN defined: SHALL add output port O_PAR (1 bit) = XOR-reduction of the result, computed at accept, stored with its entry, reset to 0, valid with O_VALID.
REQ-025 Macro LOGIC_PIPE_PARITY_EN undefined: port O_PAR and its storage SHALL be absent; all other behaviour identical.

Verification (WIDTH=3)
REQ-026 Reset then I=3'b010, MODE=00, I_VALID=1, O_READY=1 for one cycle -> next cycle O=3'b101, O_VALID=1; following cycle O_VALID=0.
REQ-027 MODE 01/10/11 with I=3'b110, K=3'b011 -> O=3'b010 / 3'b111 / 3'b101 respectively, one cycle after each accept (parity build: O_PAR=1/1/0).
REQ-028 O_READY=0, push 3'b001 then 3'b100 (MODE 00) -> I_READY=0 after second accept, O=3'b110 held; raise O_READY -> O=3'b110 then 3'b011, I_READY returns 1.
REQ-029 Streaming 8 inputs 0..7 MODE 00 with O_READY=1 continuously -> outputs 7..0 on 8 consecutive cycles, no bubbles.
REQ-030 State FULL, assert RESETN=0 mid-cycle -> O_VALID and I_READY drop immediately without CLK edge; after release, first output corresponds only to post-reset input.
REQ-031 Random I_VALID/O_READY, 10k cycles, vs. reference queue model -> zero mismatches, zero drops, zero duplicates.
